// File: rtl/traffic_sequencer_if.sv
// Traffic sequencer signal bundle.
//
// Groups the time base, the left-turn sensors and the sequencer outputs.
//   tick       : single-cycle time-base enable (one pulse per timing unit)
//   leftReqNS  : north/south left-turn sensor (level or pulse)
//   leftReqEW  : east/west left-turn sensor (level or pulse)
//   stateOut   : 3-bit phase code for the LED decoder
//   timeLeft   : ticks remaining in the current phase, minus one
//   phaseDone  : one-cycle pulse when a phase transition registers
//   pendNS     : latched north/south left request
//   pendEW     : latched east/west left request
//
// slave  : the sequencer side (consumes tick/requests, drives status).
// master : the controlling side (drives tick/requests, observes status).
interface traffic_sequencer_if;
    logic       tick;
    logic       leftReqNS;
    logic       leftReqEW;
    logic [2:0] stateOut;
    logic [7:0] timeLeft;
    logic       phaseDone;
    logic       pendNS;
    logic       pendEW;

    modport slave (
        input  tick,
        input  leftReqNS,
        input  leftReqEW,
        output stateOut,
        output timeLeft,
        output phaseDone,
        output pendNS,
        output pendEW
    );

    modport master (
        output tick,
        output leftReqNS,
        output leftReqEW,
        input  stateOut,
        input  timeLeft,
        input  phaseDone,
        input  pendNS,
        input  pendEW
    );
endinterface

// File: rtl/traffic_sequencer.sv
// Eight-phase traffic-light sequencer with demand-driven protected left turns.
//
// Phases cycle NS green, NS yellow, all-red A, [EW left], EW green, EW yellow,
// all-red B, [NS left]. Each phase lasts its configured number of ticks; the
// left phases are inserted only when a request for that direction is pending.
//
// Ports:
//   clk    : the only clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : traffic_sequencer_if.slave (tick, left requests in; phase status out)
//
// All outputs come straight from flops; there is no input-to-output path.
module traffic_sequencer #(
    parameter int unsigned T_GREEN  = 10,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_LEFT   = 5
) (
    input  logic               clk,
    input  logic               reset,
    traffic_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        NsGreen  = 3'd0,
        NsYellow = 3'd1,
        AllRedA  = 3'd2,
        EwLeft   = 3'd3,
        EwGreen  = 3'd4,
        EwYellow = 3'd5,
        AllRedB  = 3'd6,
        NsLeft   = 3'd7
    } phase_e;

    // Counter reload values: the counter runs from duration-1 down to 0.
    localparam logic [7:0] LoadGreen  = 8'(T_GREEN - 1);
    localparam logic [7:0] LoadYellow = 8'(T_YELLOW - 1);
    localparam logic [7:0] LoadAllRed = 8'(T_ALLRED - 1);
    localparam logic [7:0] LoadLeft   = 8'(T_LEFT - 1);

    phase_e     state_q, state_d;
    logic [7:0] time_left_q, time_left_d;
    logic       phase_done_q, phase_done_d;
    logic       pend_ns_q, pend_ns_d;
    logic       pend_ew_q, pend_ew_d;

    function automatic logic [7:0] load_value(input phase_e p);
        logic [7:0] v;
        case (p)
            NsGreen, EwGreen:   v = LoadGreen;
            NsYellow, EwYellow: v = LoadYellow;
            AllRedA, AllRedB:   v = LoadAllRed;
            default:            v = LoadLeft;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        time_left_d  = time_left_q;
        phase_done_d = 1'b0;
        // A request for a left phase that is currently running is ignored,
        // so a held sensor re-arms only once the phase has been left.
        pend_ns_d    = pend_ns_q | (bus.leftReqNS & (state_q != NsLeft));
        pend_ew_d    = pend_ew_q | (bus.leftReqEW & (state_q != EwLeft));

        if (bus.tick) begin
            if (time_left_q == 8'd0) begin
                case (state_q)
                    NsGreen:  state_d = NsYellow;
                    NsYellow: state_d = AllRedA;
                    // Decision point: a same-cycle request is honoured too.
                    AllRedA:  state_d = (pend_ew_q | bus.leftReqEW) ? EwLeft : EwGreen;
                    EwLeft:   state_d = EwGreen;
                    EwGreen:  state_d = EwYellow;
                    EwYellow: state_d = AllRedB;
                    AllRedB:  state_d = (pend_ns_q | bus.leftReqNS) ? NsLeft : NsGreen;
                    NsLeft:   state_d = NsGreen;
                    default:  state_d = NsGreen;
                endcase
                time_left_d  = load_value(state_d);
                phase_done_d = 1'b1;
                // Entering a left phase serves its request; clear beats set.
                if (state_d == EwLeft) begin
                    pend_ew_d = 1'b0;
                end
                if (state_d == NsLeft) begin
                    pend_ns_d = 1'b0;
                end
            end else begin
                time_left_d = time_left_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NsGreen;
            time_left_q  <= LoadGreen;
            phase_done_q <= 1'b0;
            pend_ns_q    <= 1'b0;
            pend_ew_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_left_q  <= time_left_d;
            phase_done_q <= phase_done_d;
            pend_ns_q    <= pend_ns_d;
            pend_ew_q    <= pend_ew_d;
        end
    end

    assign bus.stateOut  = state_q;
    assign bus.timeLeft  = time_left_q;
    assign bus.phaseDone = phase_done_q;
    assign bus.pendNS    = pend_ns_q;
    assign bus.pendEW    = pend_ew_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Self-checking bench for traffic_sequencer with default timing parameters.
module tb_traffic_sequencer;

    localparam int G  = 10;
    localparam int Y  = 3;
    localparam int AR = 1;
    localparam int L  = 5;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] tl;
        logic       pd;
        logic       pns;
        logic       pew;
    } exp_t;

    typedef struct packed {
        logic rst;
        logic tk;
        logic lns;
        logic lew;
        exp_t e;
    } vec_t;

    logic clk;
    logic reset;
    traffic_sequencer_if bus ();

    traffic_sequencer #(
        .T_GREEN  (G),
        .T_YELLOW (Y),
        .T_ALLRED (AR),
        .T_LEFT   (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;

    function automatic exp_t mk(input int st, input int tl, input bit pd, input bit pns,
                                input bit pew);
        exp_t e;
        e.st  = 3'(st);
        e.tl  = 8'(tl);
        e.pd  = pd;
        e.pns = pns;
        e.pew = pew;
        return e;
    endfunction

    // Appends `count` tick cycles of one phase; the counter starts at tl_start.
    function automatic void push_run(input bit rst_first, input int st, input int tl_start,
                                     input int count, input bit pd_first, input bit lns,
                                     input bit lew, input bit pns, input bit pew);
        for (int i = 0; i < count; i++) begin
            vec_t v;
            v.rst = rst_first && (i == 0);
            v.tk  = 1'b1;
            v.lns = lns;
            v.lew = lew;
            v.e   = mk(st, tl_start - i, pd_first && (i == 0), pns, pew);
            tbl.push_back(v);
        end
    endfunction

    function automatic void phase(input int st, input int dur, input bit lns, input bit lew,
                                  input bit pns, input bit pew);
        push_run(1'b0, st, dur - 1, dur, 1'b1, lns, lew, pns, pew);
    endfunction

    task automatic step(input logic rst, input logic tk, input logic lns, input logic lew,
                        input bit chk, input exp_t e, input string name);
        exp_t w;
        @(negedge clk);
        reset         = rst;
        bus.tick      = tk;
        bus.leftReqNS = lns;
        bus.leftReqEW = lew;
        if (chk) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (chk) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                w = exp_q.pop_front();
                if (bus.stateOut !== w.st || bus.timeLeft !== w.tl ||
                    bus.phaseDone !== w.pd || bus.pendNS !== w.pns || bus.pendEW !== w.pew) begin
                    n_err++;
                    $display("FAIL %s: got st=%0d tl=%0d pd=%b pns=%b pew=%b, want st=%0d tl=%0d pd=%b pns=%b pew=%b",
                             name, bus.stateOut, bus.timeLeft, bus.phaseDone, bus.pendNS,
                             bus.pendEW, w.st, w.tl, w.pd, w.pns, w.pew);
                end
            end
        end
    endtask

    task automatic chk(input logic rst, input logic tk, input logic lns, input logic lew,
                       input int st, input int tl, input bit pd, input bit pns, input bit pew,
                       input string name);
        step(rst, tk, lns, lew, 1'b1, mk(st, tl, pd, pns, pew), name);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.tick      = 1'b0;
        bus.leftReqNS = 1'b0;
        bus.leftReqEW = 1'b0;

        // No requests: one full cycle skipping both left phases.
        push_run(1'b1, 0, G - 1, G, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        phase(1, Y, 0, 0, 0, 0);
        phase(2, AR, 0, 0, 0, 0);
        phase(4, G, 0, 0, 0, 0);
        phase(5, Y, 0, 0, 0, 0);
        phase(6, AR, 0, 0, 0, 0);
        phase(0, G, 0, 0, 0, 0);
        phase(1, Y, 0, 0, 0, 0);

        // EW request pulsed during NS green: latched, then served by phase 3.
        push_run(1'b1, 0, G - 1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_run(1'b0, 0, G - 5, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        push_run(1'b0, 0, G - 6, G - 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        phase(1, Y, 0, 0, 0, 1);
        phase(2, AR, 0, 0, 0, 1);
        phase(3, L, 0, 0, 0, 0);
        phase(4, G, 0, 0, 0, 0);
        phase(5, Y, 0, 0, 0, 0);
        phase(6, AR, 0, 0, 0, 0);
        phase(0, G, 0, 0, 0, 0);

        // EW request held: served once per cycle, re-latched after phase 3.
        push_run(1'b1, 0, G - 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_run(1'b0, 0, G - 2, G - 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        phase(1, Y, 0, 1, 0, 1);
        phase(2, AR, 0, 1, 0, 1);
        phase(3, L, 0, 1, 0, 0);
        push_run(1'b0, 4, G - 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_run(1'b0, 4, G - 2, G - 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        phase(5, Y, 0, 1, 0, 1);
        phase(6, AR, 0, 1, 0, 1);
        phase(0, G, 0, 1, 0, 1);
        phase(1, Y, 0, 1, 0, 1);
        phase(2, AR, 0, 1, 0, 1);
        phase(3, L, 0, 1, 0, 0);
        push_run(1'b0, 4, G - 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_run(1'b0, 4, G - 2, G - 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].tk, tbl[i].lns, tbl[i].lew, 1'b1, tbl[i].e,
                 $sformatf("vec%0d", i));
        end

        // NS request arrives exactly at the all-red B decision edge.
        chk(1, 1, 0, 0, 0, G - 1, 0, 0, 0, "r35_reset");
        run_ticks(26);
        chk(0, 1, 0, 0, 6, 0, 1, 0, 0, "r35_allred_b");
        chk(0, 1, 1, 0, 7, L - 1, 1, 0, 0, "r35_enter_ns_left");
        chk(0, 1, 1, 0, 7, L - 2, 0, 0, 0, "r35_ns_req_ignored");
        run_ticks(3);
        chk(0, 1, 0, 0, 0, G - 1, 1, 0, 0, "r35_left_to_green");

        // Sparse tick: one every 4th cycle stretches yellow to 12 clocks.
        chk(1, 1, 0, 0, 0, G - 1, 0, 0, 0, "r36_reset");
        run_ticks(9);
        chk(0, 1, 0, 0, 1, 2, 1, 0, 0, "r36_enter_yellow");
        for (int i = 0; i < 3; i++) chk(0, 0, 0, 0, 1, 2, 0, 0, 0, "r36_hold2");
        for (int t = 1; t >= 0; t--) begin
            chk(0, 1, 0, 0, 1, t, 0, 0, 0, "r36_tick");
            for (int i = 0; i < 3; i++) chk(0, 0, 0, 0, 1, t, 0, 0, 0, "r36_hold");
        end
        chk(0, 1, 0, 0, 2, 0, 1, 0, 0, "r36_leave_yellow");

        // Reset mid-yellow with a pending NS request and active inputs.
        chk(1, 1, 0, 0, 0, G - 1, 0, 0, 0, "r37_reset");
        chk(0, 1, 1, 0, 0, G - 2, 0, 1, 0, "r37_ns_req");
        run_ticks(23);
        chk(0, 1, 0, 0, 5, 1, 0, 1, 0, "r37_yellow_tl1");
        chk(1, 1, 1, 1, 0, G - 1, 0, 0, 0, "r37_reset_mid");
        chk(0, 1, 0, 0, 0, G - 2, 0, 0, 0, "r37_restart");
        chk(0, 0, 0, 0, 0, G - 2, 0, 0, 0, "r37_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
